// File: rtl/adder_share_arb.sv
// Round-robin arbiter that shares one sequential adder among NUM_REQ requesters.
// A one-hot tag pipeline follows each issued pair so its sum returns to its owner.
module adder_share_arb #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 4,
  parameter int ADD_LATENCY = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_en,
  input  logic [NUM_REQ-1:0]                 i_req_valid,
  input  logic [NUM_REQ*2*DATA_WIDTH-1:0]    i_req_data_bus,
  output logic [NUM_REQ-1:0]                 o_req_ready,
  output logic [1:0]                         o_add_valid,
  output logic [2*DATA_WIDTH-1:0]            o_add_data_bus,
  output logic                               o_add_en,
  input  logic                               i_add_valid,
  input  logic [DATA_WIDTH:0]                i_add_data_bus,
  output logic [NUM_REQ-1:0]                 o_rsp_valid,
  output logic [DATA_WIDTH:0]                o_rsp_data,
  output logic                               o_err
);

  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PAIR_W = 2 * DATA_WIDTH;
  localparam logic [PTR_W:0]   NUM_REQ_C = (PTR_W + 1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]    ptr_q;
  logic [PTR_W-1:0]    ptr_d;
  logic [PTR_W:0]      cand_s;
  logic [PTR_W-1:0]    grant_idx_s;
  logic                grant_any_s;
  logic [NUM_REQ-1:0]  grant_s;
  logic [PAIR_W-1:0]   pair_s;
  logic [NUM_REQ-1:0]  tag_q [ADD_LATENCY];
  logic [NUM_REQ-1:0]  tail_s;
  logic                tail_nz_s;
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic [DATA_WIDTH:0] rsp_data_q;
  logic                err_q;

  // Rotating priority search starting at the pointer; reset and disable suppress any grant
  always_comb begin
    grant_idx_s = '0;
    grant_any_s = 1'b0;
    cand_s      = '0;
    if (i_en && !rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cand_s = {1'b0, ptr_q} + (PTR_W + 1)'(i);
        if (cand_s >= NUM_REQ_C) begin
          cand_s = cand_s - NUM_REQ_C;
        end else begin
          cand_s = cand_s;
        end
        if (!grant_any_s && i_req_valid[cand_s[PTR_W-1:0]]) begin
          grant_any_s = 1'b1;
          grant_idx_s = cand_s[PTR_W-1:0];
        end else begin
          grant_any_s = grant_any_s;
        end
      end
    end else begin
      grant_any_s = 1'b0;
    end
  end

  assign grant_s = grant_any_s ? (NUM_REQ'(1) << grant_idx_s) : '0;

  // Operand mux: the one-hot grant selects exactly one pair, or none
  always_comb begin
    pair_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_s[k]) begin
        pair_s = pair_s | i_req_data_bus[k*PAIR_W +: PAIR_W];
      end else begin
        pair_s = pair_s;
      end
    end
  end

  // Next pointer is one past the winner, wrapping at NUM_REQ
  always_comb begin
    ptr_d = ptr_q;
    if (grant_any_s) begin
      if (grant_idx_s == LAST_IDX) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx_s + PTR_W'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Tag pipeline mirrors the adder latency and freezes with it while disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < ADD_LATENCY; j++) begin
        tag_q[j] <= '0;
      end
    end else if (i_en) begin
      tag_q[0] <= grant_s;
      for (int j = 1; j < ADD_LATENCY; j++) begin
        tag_q[j] <= tag_q[j-1];
      end
    end else begin
      for (int j = 0; j < ADD_LATENCY; j++) begin
        tag_q[j] <= tag_q[j];
      end
    end
  end

  assign tail_s    = tag_q[ADD_LATENCY-1];
  assign tail_nz_s = |tail_s;

  // Pointer, response strobe and sticky error; a stalled adder never yields a response
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else if (i_en) begin
      ptr_q <= ptr_d;
      if (i_add_valid && tail_nz_s) begin
        rsp_valid_q <= tail_s;
        rsp_data_q  <= i_add_data_bus;
      end else begin
        rsp_valid_q <= '0;
        rsp_data_q  <= rsp_data_q;
      end
      if (i_add_valid != tail_nz_s) begin
        err_q <= 1'b1;
      end else begin
        err_q <= err_q;
      end
    end else begin
      ptr_q       <= ptr_q;
      rsp_valid_q <= '0;
      rsp_data_q  <= rsp_data_q;
      err_q       <= err_q;
    end
  end

  assign o_req_ready    = grant_s;
  assign o_add_valid    = grant_any_s ? 2'b11 : 2'b00;
  assign o_add_data_bus = pair_s;
  assign o_add_en       = i_en;
  assign o_rsp_valid    = rsp_valid_q;
  assign o_rsp_data     = rsp_data_q;
  assign o_err          = err_q;

endmodule

// File: tb/tb_adder_share_arb.sv
// Bench for adder_share_arb: directed vector table, then randomized traffic
// checked against a queue-based model of grant order and response timing.
module tb_adder_share_arb;

  localparam int N  = 4;
  localparam int DW = 4;
  localparam int L  = 1;
  localparam int PW = 2 * DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            en;
  logic            orphan;
  logic [N-1:0]    req_valid;
  logic [N*PW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [1:0]      add_valid;
  logic [PW-1:0]   add_data;
  logic            add_en;
  logic            add_v_in;
  logic [DW:0]     add_sum_in;
  logic [N-1:0]    rsp_valid;
  logic [DW:0]     rsp_data;
  logic            err;
  logic            add_v_q;
  logic [DW:0]     add_s_q;

  int errors = 0;
  int checks = 0;

  adder_share_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADD_LATENCY(L)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_en           (en),
    .i_req_valid    (req_valid),
    .i_req_data_bus (req_data),
    .o_req_ready    (req_ready),
    .o_add_valid    (add_valid),
    .o_add_data_bus (add_data),
    .o_add_en       (add_en),
    .i_add_valid    (add_v_in),
    .i_add_data_bus (add_sum_in),
    .o_rsp_valid    (rsp_valid),
    .o_rsp_data     (rsp_data),
    .o_err          (err)
  );

  // Stand-in for the shared adder: one-cycle registered sum, frozen while disabled
  always @(posedge clk) begin
    if (rst) begin
      add_v_q <= 1'b0;
      add_s_q <= '0;
    end else if (add_en) begin
      add_v_q <= &add_valid;
      add_s_q <= {1'b0, add_data[PW-1:DW]} + {1'b0, add_data[DW-1:0]};
    end
  end
  assign add_v_in   = add_v_q | orphan;
  assign add_sum_in = add_s_q;

  typedef struct {
    logic            rst;
    logic            en;
    logic            orph;
    logic [N-1:0]    v;
    logic [N*PW-1:0] d;
    logic [N-1:0]    r;
    logic [N-1:0]    rv;
    logic [DW:0]     rd;
    logic            e;
  } vec_t;

  typedef struct {
    int          owner;
    logic [DW:0] sum;
    int          age;
  } fl_t;

  fl_t         fq[$];
  int          m_ptr = 0;
  logic [N-1:0] m_rsp_v = '0;
  logic [DW:0]  m_rsp_d = '0;
  logic         m_err = 1'b0;
  logic [N-1:0] pend = '0;
  vec_t         tab[$];

  function automatic vec_t mk(input logic r_i, input logic e_i, input logic o_i,
                              input logic [N-1:0] v_i, input logic [N*PW-1:0] d_i,
                              input logic [N-1:0] rdy_i, input logic [N-1:0] rv_i,
                              input logic [DW:0] rd_i, input logic err_i);
    vec_t t;
    t.rst = r_i; t.en = e_i; t.orph = o_i; t.v = v_i; t.d = d_i;
    t.r = rdy_i; t.rv = rv_i; t.rd = rd_i; t.e = err_i;
    return t;
  endfunction

  function automatic int ref_grant(input logic r, input logic e, input logic [N-1:0] v, input int p);
    logic [N-1:0] sh;
    if (r || !e) return -1;
    for (int i = 0; i < N; i++) begin
      sh = v >> ((p + i) % N);
      if (sh[0]) return (p + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [PW-1:0] pair_of(input logic [N*PW-1:0] bus, input int g);
    logic [N*PW-1:0] sh;
    sh = bus >> (g * PW);
    return sh[PW-1:0];
  endfunction

  function automatic logic [N*PW-1:0] set_pair(input logic [N*PW-1:0] bus, input int k, input logic [PW-1:0] p);
    logic [N*PW-1:0] m;
    m = (N*PW)'({PW{1'b1}}) << (k * PW);
    return (bus & ~m) | ((N*PW)'(p) << (k * PW));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: compare mid-cycle, then advance the model across the coming edge
  task automatic step(input bit use_tab, input vec_t t);
    int           g;
    logic [N-1:0] exp_r;
    logic [PW-1:0] exp_p;
    logic [DW:0]  exp_sum;
    bit           due;
    fl_t          ent;
    @(negedge clk);
    g       = ref_grant(rst, en, req_valid, m_ptr);
    exp_r   = (g >= 0) ? (N'(1) << g) : '0;
    exp_p   = (g >= 0) ? pair_of(req_data, g) : '0;
    exp_sum = {1'b0, exp_p[PW-1:DW]} + {1'b0, exp_p[DW-1:0]};
    chk("ready",     32'(req_ready), 32'(exp_r));
    chk("add_valid", 32'(add_valid), (g >= 0) ? 32'd3 : 32'd0);
    chk("add_data",  32'(add_data),  32'(exp_p));
    chk("add_en",    32'(add_en),    32'(en));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_v));
    chk("rsp_data",  32'(rsp_data),  32'(m_rsp_d));
    chk("err",       32'(err),       32'(m_err));
    if (use_tab) begin
      chk("tab_ready",     32'(req_ready), 32'(t.r));
      chk("tab_rsp_valid", 32'(rsp_valid), 32'(t.rv));
      chk("tab_rsp_data",  32'(rsp_data),  32'(t.rd));
      chk("tab_err",       32'(err),       32'(t.e));
    end
    if (rst) begin
      m_ptr = 0; fq.delete(); m_rsp_v = '0; m_rsp_d = '0; m_err = 1'b0;
    end else if (en) begin
      due = (fq.size() > 0) && (fq[0].age == L - 1);
      if (add_v_in && due) begin
        m_rsp_v = N'(1) << fq[0].owner;
        m_rsp_d = fq[0].sum;
      end else begin
        m_rsp_v = '0;
      end
      if (add_v_in != due) m_err = 1'b1;
      if (due) void'(fq.pop_front());
      foreach (fq[i]) fq[i].age = fq[i].age + 1;
      if (g >= 0) begin
        ent.owner = g; ent.sum = exp_sum; ent.age = 0;
        fq.push_back(ent);
        m_ptr = (g + 1) % N;
        pend = pend & ~(N'(1) << g);
      end
    end else begin
      m_rsp_v = '0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; orphan = 1'b0; req_valid = '0; req_data = '0;
    @(posedge clk);
    #1;

    // rst, en, orphan, valid, data, exp ready, exp rsp_valid, exp rsp_data, exp err
    tab.push_back(mk(1, 1, 0, 4'hF, 32'h7856_3412, 4'h0, 4'h0, 5'h00, 0));
    tab.push_back(mk(1, 1, 0, 4'hF, 32'h7856_3412, 4'h0, 4'h0, 5'h00, 0));
    tab.push_back(mk(0, 1, 0, 4'hF, 32'h7856_3412, 4'h1, 4'h0, 5'h00, 0));
    tab.push_back(mk(0, 1, 0, 4'hF, 32'h7856_349A, 4'h2, 4'h0, 5'h00, 0));
    tab.push_back(mk(0, 1, 0, 4'hF, 32'h7856_BC9A, 4'h4, 4'h1, 5'h03, 0));
    tab.push_back(mk(0, 1, 0, 4'hF, 32'h78DE_BC9A, 4'h8, 4'h2, 5'h07, 0));
    tab.push_back(mk(0, 1, 0, 4'hF, 32'hF0DE_BC9A, 4'h1, 4'h4, 5'h0B, 0));
    tab.push_back(mk(0, 1, 0, 4'hF, 32'hF0DE_BC11, 4'h2, 4'h8, 5'h0F, 0));
    tab.push_back(mk(0, 1, 0, 4'h0, 32'hF0DE_BC11, 4'h0, 4'h1, 5'h13, 0));
    tab.push_back(mk(0, 1, 0, 4'h0, 32'hF0DE_BC11, 4'h0, 4'h2, 5'h17, 0));
    tab.push_back(mk(0, 1, 0, 4'h0, 32'h0000_0000, 4'h0, 4'h0, 5'h17, 0));
    tab.push_back(mk(0, 1, 0, 4'h4, 32'h0034_0000, 4'h4, 4'h0, 5'h17, 0));
    tab.push_back(mk(0, 1, 0, 4'h0, 32'h0000_0000, 4'h0, 4'h0, 5'h17, 0));
    tab.push_back(mk(0, 1, 0, 4'h0, 32'h0000_0000, 4'h0, 4'h4, 5'h07, 0));
    tab.push_back(mk(0, 1, 0, 4'h0, 32'h0000_0000, 4'h0, 4'h0, 5'h07, 0));
    tab.push_back(mk(0, 1, 0, 4'h3, 32'h0000_F1FF, 4'h1, 4'h0, 5'h07, 0));
    tab.push_back(mk(0, 1, 0, 4'h2, 32'h0000_F1FF, 4'h2, 4'h0, 5'h07, 0));
    tab.push_back(mk(0, 1, 0, 4'h0, 32'h0000_0000, 4'h0, 4'h1, 5'h1E, 0));
    tab.push_back(mk(0, 1, 0, 4'h0, 32'h0000_0000, 4'h0, 4'h2, 5'h10, 0));
    tab.push_back(mk(0, 1, 0, 4'h0, 32'h0000_0000, 4'h0, 4'h0, 5'h10, 0));
    tab.push_back(mk(0, 1, 0, 4'h8, 32'h2500_0000, 4'h8, 4'h0, 5'h10, 0));
    tab.push_back(mk(0, 0, 0, 4'h1, 32'h0000_0011, 4'h0, 4'h0, 5'h10, 0));
    tab.push_back(mk(0, 0, 0, 4'h1, 32'h0000_0011, 4'h0, 4'h0, 5'h10, 0));
    tab.push_back(mk(0, 0, 0, 4'h1, 32'h0000_0011, 4'h0, 4'h0, 5'h10, 0));
    tab.push_back(mk(0, 1, 0, 4'h1, 32'h0000_0011, 4'h1, 4'h0, 5'h10, 0));
    tab.push_back(mk(0, 1, 0, 4'h0, 32'h0000_0000, 4'h0, 4'h8, 5'h07, 0));
    tab.push_back(mk(0, 1, 0, 4'h0, 32'h0000_0000, 4'h0, 4'h1, 5'h02, 0));
    tab.push_back(mk(0, 1, 0, 4'h0, 32'h0000_0000, 4'h0, 4'h0, 5'h02, 0));
    tab.push_back(mk(0, 1, 0, 4'h4, 32'h0033_0000, 4'h4, 4'h0, 5'h02, 0));
    tab.push_back(mk(1, 1, 0, 4'h0, 32'h0000_0000, 4'h0, 4'h0, 5'h02, 0));
    tab.push_back(mk(0, 1, 0, 4'h0, 32'h0000_0000, 4'h0, 4'h0, 5'h00, 0));
    tab.push_back(mk(0, 1, 0, 4'h9, 32'h2200_0044, 4'h1, 4'h0, 5'h00, 0));
    tab.push_back(mk(0, 1, 0, 4'h8, 32'h2200_0044, 4'h8, 4'h0, 5'h00, 0));
    tab.push_back(mk(0, 1, 0, 4'h0, 32'h0000_0000, 4'h0, 4'h1, 5'h08, 0));
    tab.push_back(mk(0, 1, 0, 4'h0, 32'h0000_0000, 4'h0, 4'h8, 5'h04, 0));
    tab.push_back(mk(0, 1, 1, 4'h0, 32'h0000_0000, 4'h0, 4'h0, 5'h04, 0));
    tab.push_back(mk(0, 1, 0, 4'h0, 32'h0000_0000, 4'h0, 4'h0, 5'h04, 1));
    tab.push_back(mk(0, 1, 0, 4'h0, 32'h0000_0000, 4'h0, 4'h0, 5'h04, 1));
    tab.push_back(mk(1, 1, 0, 4'h0, 32'h0000_0000, 4'h0, 4'h0, 5'h04, 1));
    tab.push_back(mk(0, 1, 0, 4'h0, 32'h0000_0000, 4'h0, 4'h0, 5'h00, 0));

    for (int i = 0; i < tab.size(); i++) begin
      rst       = tab[i].rst;
      en        = tab[i].en;
      orphan    = tab[i].orph;
      req_valid = tab[i].v;
      req_data  = tab[i].d;
      step(1'b1, tab[i]);
    end

    // Random traffic: requesters hold data until their handshake completes
    pend   = '0;
    orphan = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      en  = ($urandom_range(0, 9) != 0);
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && ($urandom_range(0, 99) < 45)) begin
          pend     = pend | (N'(1) << k);
          req_data = set_pair(req_data, k, PW'($urandom));
        end
      end
      req_valid = pend;
      step(1'b0, tab[0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
